// File: rtl/pc_ras_unit_pkg.sv
// Shared opcode definitions and small decode helpers for the front-end PC logic.
package pc_ras_unit_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_NAND = 4'h2,
    OP_XOR  = 4'h3,
    OP_INC  = 4'h4,
    OP_SRA  = 4'h5,
    OP_SRL  = 4'h6,
    OP_SLL  = 4'h7,
    OP_SW   = 4'h8,
    OP_LW   = 4'h9,
    OP_LHB  = 4'hA,
    OP_LLB  = 4'hB,
    OP_B    = 4'hC,
    OP_CALL = 4'hD,
    OP_RET  = 4'hE
  } opcode_t;

  localparam int CALL_FIELD_W = 12;

  // Opcode 4'hF is undefined and decodes to an out-of-set value that falls to pc+1.
  function automatic opcode_t decode_opcode(input logic [15:0] instr);
    return opcode_t'(instr[15:12]);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: top pointer plus saturating count, sticky overflow/underflow.
module ras_stack #(
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [PC_W-1:0]              push_data,
  output logic [PC_W-1:0]              top_data,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         ovf,
  output logic                         unf
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  logic [PC_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;

  assign empty    = (count == '0);
  assign full     = (count == CNT_MAX);
  assign top_data = mem[ptr - PTR_ONE];

  // Storage is deliberately not reset; entries are unreachable while count is zero.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      ptr <= ptr + PTR_ONE;
      if (full) begin
        ovf <= 1'b1;
      end else begin
        count <= count + CNT_ONE;
      end
    end else if (pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        ptr   <= ptr - PTR_ONE;
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Registered program counter with next-PC selection and an internal return-address stack.
module pc_ras_unit
  import pc_ras_unit_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              RAS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic [15:0]                 instr,
  input  logic                        branch,
  output logic [PC_W-1:0]             pc,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_empty,
  output logic                        ras_full,
  output logic                        ras_ovf,
  output logic                        ras_unf
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
  localparam logic [PC_W-1:0] PC_TWO = PC_W'(2);

  opcode_t         op;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] imm_sext;
  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] top_data;
  logic            push;
  logic            pop;

  assign op       = decode_opcode(instr);
  assign pc_inc   = pc + PC_ONE;
  assign imm_sext = {{(PC_W-8){instr[7]}}, instr[7:0]};

  // Stack operations are gated by stall so a held CALL/RET pushes or pops once, on release.
  always_comb begin
    next_pc = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    case (op)
      OP_B: begin
        if (branch) next_pc = pc + PC_TWO + imm_sext;
      end
      OP_CALL: begin
        push    = !stall;
        next_pc = {pc[PC_W-1:CALL_FIELD_W], instr[CALL_FIELD_W-1:0]};
      end
      OP_RET: begin
        pop = !stall;
        if (!ras_empty) next_pc = top_data;
      end
      default: next_pc = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (!stall) begin
      pc <= next_pc;
    end
  end

  ras_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (top_data),
    .count     (ras_count),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

endmodule

// File: tb/tb_pc_ras_unit.sv
// Bench for pc_ras_unit: directed vector tables plus randomized traffic against a queue-based model.
module tb_pc_ras_unit;
  import pc_ras_unit_pkg::*;

  localparam int          PC_W      = 16;
  localparam int          RAS_DEPTH = 4;
  localparam int          CW        = 3;
  localparam logic [15:0] RESET_PC  = 16'h0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic [15:0]   instr;
  logic          branch;
  logic [15:0]   pc;
  logic [CW-1:0] ras_count;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_ovf;
  logic          ras_unf;

  pc_ras_unit #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .instr     (instr),
    .branch    (branch),
    .pc        (pc),
    .ras_count (ras_count),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state: return stack as a queue, newest at the back
  logic [15:0] m_pc;
  logic [15:0] exp_q[$];
  logic        m_ovf;
  logic        m_unf;

  typedef struct {
    logic          r;
    logic          s;
    logic [15:0]   i;
    logic          b;
    logic [15:0]   pc;
    logic [CW-1:0] cnt;
    logic          ovf;
    logic          unf;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input opcode_t op, input logic [11:0] f);
    return {op, f};
  endfunction

  task automatic model_step(input logic r, input logic s, input logic [15:0] i, input logic b);
    int off;
    if (r) begin
      m_pc = RESET_PC;
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (!s) begin
      if (i[15:12] == OP_B) begin
        off  = $signed(i[7:0]);
        m_pc = b ? 16'(int'(m_pc) + 2 + off) : 16'(int'(m_pc) + 1);
      end else if (i[15:12] == OP_CALL) begin
        if (exp_q.size() == RAS_DEPTH) begin
          void'(exp_q.pop_front());
          m_ovf = 1'b1;
        end
        exp_q.push_back(16'(int'(m_pc) + 1));
        m_pc = {m_pc[15:12], i[11:0]};
      end else if (i[15:12] == OP_RET) begin
        if (exp_q.size() > 0) begin
          m_pc = exp_q.pop_back();
        end else begin
          m_pc  = 16'(int'(m_pc) + 1);
          m_unf = 1'b1;
        end
      end else begin
        m_pc = 16'(int'(m_pc) + 1);
      end
    end
  endtask

  // driver: present one cycle of inputs, advance the model, compare after the edge
  task automatic apply(input logic r, input logic s, input logic [15:0] i, input logic b);
    rst    = r;
    stall  = s;
    instr  = i;
    branch = b;
    model_step(r, s, i, b);
    @(posedge clk);
    #1;
    check("pc", 32'(pc), 32'(m_pc));
    check("ras_count", 32'(ras_count), 32'(exp_q.size()));
    check("ras_empty", 32'(ras_empty), 32'(exp_q.size() == 0));
    check("ras_full", 32'(ras_full), 32'(exp_q.size() == RAS_DEPTH));
    check("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
    check("ras_unf", 32'(ras_unf), 32'(m_unf));
  endtask

  task automatic add_vec(input logic r, input logic s, input logic [15:0] i, input logic b,
                         input logic [15:0] epc, input int ecnt, input logic eovf, input logic eunf);
    vec_t v;
    v.r = r; v.s = s; v.i = i; v.b = b;
    v.pc = epc; v.cnt = CW'(ecnt); v.ovf = eovf; v.unf = eunf;
    tbl.push_back(v);
  endtask

  task automatic run_vecs(input string tag);
    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].r, tbl[k].s, tbl[k].i, tbl[k].b);
      check($sformatf("%s[%0d].pc", tag, k), 32'(pc), 32'(tbl[k].pc));
      check($sformatf("%s[%0d].cnt", tag, k), 32'(ras_count), 32'(tbl[k].cnt));
      check($sformatf("%s[%0d].ovf", tag, k), 32'(ras_ovf), 32'(tbl[k].ovf));
      check($sformatf("%s[%0d].unf", tag, k), 32'(ras_unf), 32'(tbl[k].unf));
    end
    tbl.delete();
  endtask

  // walk the model pc to a target using taken branches (and one ADD for a distance of 1)
  task automatic goto_pc(input logic [15:0] target);
    int d;
    int imm;
    int steps = 0;
    while (m_pc != target && steps < 2000) begin
      d = int'($signed(16'(target - m_pc)));
      if (d == 1) begin
        apply(1'b0, 1'b0, mk(OP_ADD, 12'h000), 1'b0);
      end else begin
        imm = d - 2;
        if (imm > 127) imm = 127;
        if (imm < -128) imm = -128;
        apply(1'b0, 1'b0, {OP_B, 4'h0, 8'(imm)}, 1'b1);
      end
      steps++;
    end
    check("goto_pc_reached", 32'(m_pc), 32'(target));
  endtask

  initial begin
    logic [3:0]  op;
    logic        r;
    logic        s;
    rst = 1'b1; stall = 1'b0; instr = '0; branch = 1'b0;
    m_pc = RESET_PC; m_ovf = 1'b0; m_unf = 1'b0;

    // reset then straight-line code
    add_vec(1, 0, mk(OP_ADD, 12'h000), 0, 16'h0000, 0, 0, 0);
    add_vec(0, 0, mk(OP_ADD, 12'h000), 0, 16'h0001, 0, 0, 0);
    add_vec(0, 0, mk(OP_ADD, 12'h000), 0, 16'h0002, 0, 0, 0);
    add_vec(0, 0, mk(OP_ADD, 12'h000), 0, 16'h0003, 0, 0, 0);
    run_vecs("reset_seq");

    // branches: not taken, taken with zero offset, taken backwards with wrap
    goto_pc(16'h1055);
    add_vec(0, 0, mk(OP_B, 12'h000), 0, 16'h1056, 0, 0, 0);
    run_vecs("b_nt");
    goto_pc(16'h1055);
    add_vec(0, 0, mk(OP_B, 12'h000), 1, 16'h1057, 0, 0, 0);
    run_vecs("b_t0");
    goto_pc(16'h0055);
    add_vec(0, 0, mk(OP_B, 12'h0AB), 1, 16'h0002, 0, 0, 0);
    run_vecs("b_neg");

    // CALL/RET pair, then nested calls overflowing a depth-4 stack
    goto_pc(16'hC0DA);
    add_vec(0, 0, mk(OP_CALL, 12'h000), 0, 16'hC000, 1, 0, 0);
    add_vec(0, 0, mk(OP_RET,  12'h000), 0, 16'hC0DB, 0, 0, 0);
    add_vec(0, 0, mk(OP_CALL, 12'h100), 0, 16'hC100, 1, 0, 0);
    add_vec(0, 0, mk(OP_CALL, 12'h200), 0, 16'hC200, 2, 0, 0);
    add_vec(0, 0, mk(OP_CALL, 12'h300), 0, 16'hC300, 3, 0, 0);
    add_vec(0, 0, mk(OP_CALL, 12'h400), 0, 16'hC400, 4, 0, 0);
    add_vec(0, 0, mk(OP_CALL, 12'h500), 0, 16'hC500, 4, 1, 0);
    add_vec(0, 0, mk(OP_RET,  12'h000), 0, 16'hC401, 3, 1, 0);
    add_vec(0, 0, mk(OP_RET,  12'h000), 0, 16'hC301, 2, 1, 0);
    add_vec(0, 0, mk(OP_RET,  12'h000), 0, 16'hC201, 1, 1, 0);
    add_vec(0, 0, mk(OP_RET,  12'h000), 0, 16'hC101, 0, 1, 0);
    add_vec(0, 0, mk(OP_RET,  12'h000), 0, 16'hC102, 0, 1, 1);
    // stall holds everything, release performs one push
    add_vec(0, 1, mk(OP_CALL, 12'h600), 0, 16'hC102, 0, 1, 1);
    add_vec(0, 1, mk(OP_CALL, 12'h600), 0, 16'hC102, 0, 1, 1);
    add_vec(0, 1, mk(OP_CALL, 12'h600), 0, 16'hC102, 0, 1, 1);
    add_vec(0, 0, mk(OP_CALL, 12'h600), 0, 16'hC600, 1, 1, 1);
    // reset wins over stall and a pending CALL with three entries live
    add_vec(0, 0, mk(OP_CALL, 12'h700), 0, 16'hC700, 2, 1, 1);
    add_vec(0, 0, mk(OP_CALL, 12'h800), 0, 16'hC800, 3, 1, 1);
    add_vec(1, 1, mk(OP_CALL, 12'h900), 0, 16'h0000, 0, 0, 0);
    add_vec(0, 0, mk(OP_RET,  12'h000), 0, 16'h0001, 0, 0, 1);
    run_vecs("call_ret");

    // randomized traffic biased toward stack activity
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = OP_CALL;
        3, 4, 5: op = OP_RET;
        6, 7:    op = OP_B;
        default: op = 4'($urandom_range(0, 15));
      endcase
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 9) == 0);
      apply(r, s, {op, 12'($urandom)}, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
